// File: rtl/de1_soc_switch_pkg.sv
// Shared definitions for the slide-switch poller: FSM encoding and PIO register map.
package de1_soc_switch_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_READ    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;

endpackage

// File: rtl/de1_soc_switch_event_fifo.sv
// Event FIFO: first-word-fall-through queue of switch-change records.
// Latency: push visible on dout the cycle after the push edge when empty.
// Backpressure: push while full is accepted only together with a pop.
module de1_soc_switch_event_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic          full,
    input  logic          pop,
    output logic          empty,
    output logic [DW-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_push_ok;
    logic          w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/de1_soc_switch_poller.sv
// Slide-switch poller: masks PIO irq, polls the data register, debounces, queues changes.
// Latency: commit visible one cycle after the CAPTURE cycle of the STABLE_COUNT-th equal poll.
// Backpressure: ev_valid/ev_ready; a commit into a full FIFO without a pop is dropped and sets overflow.
module de1_soc_switch_poller #(
    parameter int WIDTH        = 10,
    parameter int POLL_DIV     = 50000,
    parameter int STABLE_COUNT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [1:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [2*WIDTH-1:0] ev_data,
    output logic [WIDTH-1:0]   stable_state,
    input  logic               irq_en,
    output logic               irq,
    output logic               overflow,
    input  logic               overflow_clr
);

    import de1_soc_switch_pkg::*;

    localparam int TW = $clog2(POLL_DIV);
    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(STABLE_COUNT);

    state_t             r_state;
    logic               r_cs;
    logic               r_wn;
    logic [1:0]         r_addr;
    logic [TW-1:0]      r_tick_cnt;
    logic [WIDTH-1:0]   r_cand;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_stable;
    logic               r_overflow;

    logic               w_tick;
    logic               w_capture;
    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   w_cand_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_commit;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;
    logic               w_unused_rd;

    assign w_tick      = (r_tick_cnt == TICK_LAST);
    assign w_capture   = (r_state == ST_CAPTURE);
    assign w_s         = m_readdata[WIDTH-1:0];
    assign w_unused_rd = ^m_readdata[31:WIDTH];

    // Bus registers hold the INIT write from reset so it is on the bus in the
    // first cycle after release; reset itself forces the bus idle.
    assign m_chipselect = r_cs & ~reset;
    assign m_write_n    = r_wn | reset;
    assign m_address    = reset ? ADDR_DATA : r_addr;
    assign m_writedata  = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= ADDR_IRQ_MASK;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b0;
                    r_wn    <= 1'b1;
                    r_addr  <= ADDR_DATA;
                end
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_READ;
                        r_cs    <= 1'b1;
                        r_wn    <= 1'b1;
                        r_addr  <= ADDR_DATA;
                    end
                end
                ST_READ: begin
                    r_state <= ST_CAPTURE;
                    r_cs    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b0;
                    r_wn    <= 1'b1;
                    r_addr  <= ADDR_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_tick_cnt <= '0;
        else                 r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (w_s != r_cand) begin
            w_cand_nxt = w_s;
            w_cnt_nxt  = CW'(1);
        end else if (r_cnt < CNT_DONE) begin
            w_cnt_nxt  = r_cnt + CW'(1);
        end
    end

    assign w_commit = w_capture && (w_cnt_nxt == CNT_DONE) && (w_cand_nxt != r_stable);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (w_capture) begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_commit) r_stable <= w_cand_nxt;
        end
    end

    // The committed value advances even when its event cannot be queued.
    assign w_pop  = ev_valid & ev_ready;
    assign w_drop = w_commit & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset)             r_overflow <= 1'b0;
        else if (w_drop)       r_overflow <= 1'b1;
        else if (overflow_clr) r_overflow <= 1'b0;
    end

    de1_soc_switch_event_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_commit),
        .din   ({w_cand_nxt, w_cand_nxt ^ r_stable}),
        .full  (w_full),
        .pop   (w_pop),
        .empty (w_empty),
        .dout  (ev_data)
    );

    assign ev_valid     = ~w_empty;
    assign irq          = ev_valid & irq_en;
    assign stable_state = r_stable;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_de1_soc_switch_poller.sv
// Self-checking bench for de1_soc_switch_poller with a registered-readdata PIO model.
module tb_de1_soc_switch_poller;

    localparam int WIDTH = 10;
    localparam int DW    = 2*WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       m_address;
    logic             m_chipselect;
    logic             m_write_n;
    logic [31:0]      m_writedata;
    logic [31:0]      m_readdata = 32'd0;
    logic             ev_valid;
    logic             ev_ready;
    logic [DW-1:0]    ev_data;
    logic [WIDTH-1:0] stable_state;
    logic             irq_en;
    logic             irq;
    logic             overflow;
    logic             overflow_clr;

    logic [WIDTH-1:0] in_port;
    int               rd_cnt = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    logic [DW-1:0]    exp_q[$];

    de1_soc_switch_poller #(
        .WIDTH        (WIDTH),
        .POLL_DIV     (4),
        .STABLE_COUNT (3),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_data      (ev_data),
        .stable_state (stable_state),
        .irq_en       (irq_en),
        .irq          (irq),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // PIO model: data register sampled on the read strobe, presented one cycle later.
    always @(posedge clk) begin
        m_readdata <= (m_chipselect && m_write_n && m_address == 2'd0) ? {22'd0, in_port} : 32'd0;
        if (m_chipselect && m_write_n) rd_cnt <= rd_cnt + 1;
    end

    task automatic do_reset;
        reset = 1'b1; ev_ready = 1'b0; overflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Returns at #1 after the edge that ends the n-th further READ cycle (i.e. inside CAPTURE).
    task automatic wait_reads(input int n);
        int target;
        target = rd_cnt + n;
        for (int k = 0; k < 64 && rd_cnt < target; k++) begin
            @(posedge clk); #1;
        end
        if (rd_cnt < target) begin
            n_checks++;
            $display("FAIL poll_timeout reads got %0d want %0d", rd_cnt, target);
        end
    endtask

    // Returns in the cycle after the n-th poll's CAPTURE, when any commit is visible.
    task automatic wait_polls(input int n);
        wait_reads(n);
        @(posedge clk); #1;
    endtask

    task automatic pop_entry(output logic v, output logic [DW-1:0] d);
        v = ev_valid; d = ev_data;
        ev_ready = 1'b1;
        @(posedge clk); #1;
        ev_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [12:0] wr_mask, rd_mask;
        logic        bad_rd_addr;
        reset = 1'b1; ev_ready = 1'b0; irq_en = 1'b1; overflow_clr = 1'b0; in_port = '0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL rst_ev_valid got %b want 0", ev_valid); else n_pass++;
        n_checks++; if (ev_data !== '0) $display("FAIL rst_ev_data got %h want 0", ev_data); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1)
            $display("FAIL rst_bus cs/wn got %b/%b want 0/1", m_chipselect, m_write_n); else n_pass++;
        n_checks++; if (m_address !== 2'd0 || m_writedata !== 32'd0)
            $display("FAIL rst_bus_addr addr/data got %0d/%h want 0/0", m_address, m_writedata); else n_pass++;
        n_checks++; if (stable_state !== '0) $display("FAIL rst_stable got %h want 0", stable_state); else n_pass++;
        irq_en = 1'b0;
        reset = 1'b0; #1;
        n_checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 2'd2 || m_writedata !== 32'd0)
            $display("FAIL init_write cs/wn/addr/data got %b/%b/%0d/%h want 1/0/2/0",
                     m_chipselect, m_write_n, m_address, m_writedata); else n_pass++;
        wr_mask = '0; rd_mask = '0; bad_rd_addr = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (m_chipselect && !m_write_n) wr_mask[k] = 1'b1;
            if (m_chipselect && m_write_n) begin
                rd_mask[k] = 1'b1;
                if (m_address !== 2'd0) bad_rd_addr = 1'b1;
            end
        end
        n_checks++; if (wr_mask !== 13'h0001) $display("FAIL write_pattern got %h want 0001", wr_mask); else n_pass++;
        n_checks++; if (rd_mask !== 13'h1110) $display("FAIL read_pattern got %h want 1110", rd_mask); else n_pass++;
        n_checks++; if (bad_rd_addr !== 1'b0) $display("FAIL read_address got bad=%b want 0", bad_rd_addr); else n_pass++;
    endtask

    task automatic test_held;
        logic v; logic [DW-1:0] got, want;
        do_reset();
        in_port = 10'h005; exp_q.push_back({10'h005, 10'h005});
        wait_polls(2);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL held_early ev_valid got %b want 0", ev_valid); else n_pass++;
        wait_polls(1);
        n_checks++; if (ev_valid !== 1'b1) $display("FAIL held_ev_valid got %b want 1", ev_valid); else n_pass++;
        n_checks++; if (stable_state !== 10'h005) $display("FAIL held_stable got %h want 005", stable_state); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL held_irq_masked got %b want 0", irq); else n_pass++;
        irq_en = 1'b1; #1;
        n_checks++; if (irq !== 1'b1) $display("FAIL held_irq_enabled got %b want 1", irq); else n_pass++;
        pop_entry(v, got); want = exp_q.pop_front();
        n_checks++; if (!v || got !== want) $display("FAIL held_event got %h (valid %b) want %h", got, v, want); else n_pass++;
        n_checks++; if (ev_valid !== 1'b0 || irq !== 1'b0)
            $display("FAIL held_drained valid/irq got %b/%b want 0/0", ev_valid, irq); else n_pass++;
        irq_en = 1'b0;
    endtask

    task automatic test_bounce;
        logic v; logic [DW-1:0] got, want;
        int early;
        do_reset();
        early = 0;
        for (int i = 0; i < 10; i++) begin
            in_port = (i % 2 == 0) ? 10'h001 : 10'h000;
            wait_polls(1);
            if (ev_valid !== 1'b0) early++;
        end
        n_checks++; if (early != 0) $display("FAIL bounce_quiet events got %0d want 0", early); else n_pass++;
        in_port = 10'h001; exp_q.push_back({10'h001, 10'h001});
        wait_polls(2);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL bounce_early got %b want 0", ev_valid); else n_pass++;
        wait_polls(1);
        pop_entry(v, got); want = exp_q.pop_front();
        n_checks++; if (!v || got !== want) $display("FAIL bounce_event got %h (valid %b) want %h", got, v, want); else n_pass++;
        wait_polls(3);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL bounce_single got %b want 0", ev_valid); else n_pass++;
    endtask

    task automatic test_overflow;
        logic v; logic [DW-1:0] got, want;
        do_reset();
        in_port = 10'h001; exp_q.push_back({10'h001, 10'h001}); wait_polls(3);
        in_port = 10'h003; exp_q.push_back({10'h003, 10'h002}); wait_polls(3);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_not_yet got %b want 0", overflow); else n_pass++;
        in_port = 10'h007; wait_polls(3);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
        n_checks++; if (stable_state !== 10'h007) $display("FAIL ovf_stable got %h want 007", stable_state); else n_pass++;
        overflow_clr = 1'b1; @(posedge clk); #1; overflow_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            pop_entry(v, got); want = exp_q.pop_front();
            n_checks++; if (!v || got !== want) $display("FAIL ovf_event%0d got %h (valid %b) want %h", i, got, v, want); else n_pass++;
        end
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", ev_valid); else n_pass++;
    endtask

    task automatic test_full_pop;
        logic v; logic [DW-1:0] got, want;
        do_reset();
        in_port = 10'h001; exp_q.push_back({10'h001, 10'h001}); wait_polls(3);
        in_port = 10'h003; exp_q.push_back({10'h003, 10'h002}); wait_polls(3);
        in_port = 10'h007; exp_q.push_back({10'h007, 10'h004});
        wait_polls(2);
        wait_reads(1);
        pop_entry(v, got); want = exp_q.pop_front();
        n_checks++; if (!v || got !== want) $display("FAIL fullpop_head got %h (valid %b) want %h", got, v, want); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (stable_state !== 10'h007) $display("FAIL fullpop_stable got %h want 007", stable_state); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            pop_entry(v, got); want = exp_q.pop_front();
            n_checks++; if (!v || got !== want) $display("FAIL fullpop_event%0d got %h (valid %b) want %h", i, got, v, want); else n_pass++;
        end
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL fullpop_drained got %b want 0", ev_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        in_port = 10'h001; exp_q.push_back({10'h001, 10'h001}); wait_polls(3);
        n_checks++; if (ev_valid !== 1'b1) $display("FAIL mid_one_entry got %b want 1", ev_valid); else n_pass++;
        in_port = 10'h002;
        wait_reads(1);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL mid_ev_valid got %b want 0", ev_valid); else n_pass++;
        n_checks++; if (stable_state !== '0) $display("FAIL mid_stable got %h want 0", stable_state); else n_pass++;
        n_checks++; if (m_chipselect !== 1'b0) $display("FAIL mid_bus_idle got %b want 0", m_chipselect); else n_pass++;
        @(posedge clk); #1 reset = 1'b0; #1;
        n_checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 2'd2)
            $display("FAIL mid_init_write cs/wn/addr got %b/%b/%0d want 1/0/2", m_chipselect, m_write_n, m_address); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_held();
        test_bounce();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
